uart_rx: RTL and testbench

- UART receiver. Deserialises an asynchronous serial line into parallel frames.
- Line format, parameter set and bit order match the team's UART transmitter: start bit 0, data LSB first, optional even parity, 1-2 stop bits at 1.
- Sits between an external RX pin and the fabric.
- Reports each frame with a one-cycle valid strobe plus parity and framing error flags.

---
 rtl/uart_rx.sv | 170 +++++++++++++++++
 tb/tb_uart_rx.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronised line, mid-bit sampling, LSB-first data,
// optional even parity, 1-2 stop bits, one-cycle valid with sticky error flags.
module uart_rx #(
   parameter int I_CLK_FRQ = 100_000_000,
   parameter int BAUD      = 9600,
   parameter int PARITY    = 0,
   parameter int FRAME     = 8,
   parameter int STOP      = 1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_rx,
   output logic [FRAME-1:0] o_data,
   output logic             o_valid,
   output logic             o_parity_err,
   output logic             o_frame_err,
   output logic             o_busy
);

   // state       | meaning
   // S_IDLE      | line idle, waiting for a falling edge on rx_s
   // S_START     | timing to the middle of the start bit, rejecting glitches
   // S_DATA      | sampling FRAME data bits, LSB first
   // S_PAR       | sampling the even parity bit
   // S_STOP      | sampling STOP stop bits; frame completes at the last one
   // S_WAIT_IDLE | last stop bit was low (break); wait for the line to recover

   localparam int CLKS_PER_BIT = I_CLK_FRQ / BAUD;
   localparam int HALF         = CLKS_PER_BIT / 2;
   localparam int CNT_W        = $clog2(CLKS_PER_BIT);
   localparam int IDX_W        = $clog2(FRAME);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PAR,
      S_STOP,
      S_WAIT_IDLE
   } state_t;

   state_t             state, state_nxt;
   logic               rx_meta, rx_s;
   logic [CNT_W-1:0]   cnt;
   logic [IDX_W-1:0]   bit_idx;
   logic               stop_idx;
   logic [FRAME-1:0]   shift_reg;
   logic               perr_acc;
   logic               ferr_acc;

   logic               half_tick, tick;
   logic               cnt_clr, smp_data, smp_par, smp_stop, done;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= i_rx;
         rx_s    <= rx_meta;
      end
   end

   assign half_tick = (cnt == CNT_W'(HALF - 1));
   assign tick      = (cnt == CNT_W'(CLKS_PER_BIT - 1));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state <= S_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      cnt_clr   = 1'b0;
      smp_data  = 1'b0;
      smp_par   = 1'b0;
      smp_stop  = 1'b0;
      done      = 1'b0;
      case (state)
         S_IDLE: begin
            if (!rx_s) begin
               state_nxt = S_START;
               cnt_clr   = 1'b1;
            end
         end
         S_START: begin
            if (half_tick) begin
               cnt_clr   = 1'b1;
               state_nxt = rx_s ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (tick) begin
               cnt_clr  = 1'b1;
               smp_data = 1'b1;
               if (bit_idx == IDX_W'(FRAME - 1))
                  state_nxt = (PARITY != 0) ? S_PAR : S_STOP;
            end
         end
         S_PAR: begin
            if (tick) begin
               cnt_clr   = 1'b1;
               smp_par   = 1'b1;
               state_nxt = S_STOP;
            end
         end
         S_STOP: begin
            if (tick) begin
               cnt_clr  = 1'b1;
               smp_stop = 1'b1;
               if (stop_idx == 1'(STOP - 1)) begin
                  done      = 1'b1;
                  // Leaving at mid-stop lets an immediately following start edge be seen.
                  state_nxt = rx_s ? S_IDLE : S_WAIT_IDLE;
               end
            end
         end
         S_WAIT_IDLE: begin
            if (rx_s) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt       <= '0;
         bit_idx   <= '0;
         stop_idx  <= 1'b0;
         shift_reg <= '0;
         perr_acc  <= 1'b0;
         ferr_acc  <= 1'b0;
      end else begin
         if (cnt_clr || state == S_IDLE || state == S_WAIT_IDLE) cnt <= '0;
         else                                                    cnt <= cnt + CNT_W'(1);

         if (state == S_START) bit_idx <= '0;
         else if (smp_data)    bit_idx <= bit_idx + IDX_W'(1);

         if (state != S_STOP) stop_idx <= 1'b0;
         else if (smp_stop)   stop_idx <= ~stop_idx;

         if (smp_data) shift_reg[bit_idx] <= rx_s;
         if (smp_par)  perr_acc <= rx_s ^ (^shift_reg);

         if (state == S_START)          ferr_acc <= 1'b0;
         else if (smp_stop && !rx_s)    ferr_acc <= 1'b1;
      end
   end

   // Outputs change only when a frame completes; shift_reg isolates o_data from partial frames.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_data       <= '0;
         o_valid      <= 1'b0;
         o_parity_err <= 1'b0;
         o_frame_err  <= 1'b0;
      end else begin
         o_valid <= done;
         if (done) begin
            o_data       <= shift_reg;
            o_parity_err <= (PARITY != 0) ? perr_acc : 1'b0;
            o_frame_err  <= ferr_acc | ~rx_s;
         end
      end
   end

   assign o_busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: an 8N1 instance (a) and an 8E1 instance (b), both at
// 100 clocks per bit; stimulus pushes expected frames, per-instance monitors pop and compare.
module tb_uart_rx;

   typedef struct packed {
      logic [7:0] d;
      logic       pe;
      logic       fe;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx_a = 1'b1;
   logic       rx_b = 1'b1;
   logic [7:0] data_a, data_b;
   logic       valid_a, valid_b, perr_a, perr_b, ferr_a, ferr_b, busy_a, busy_b;

   int   n_pass = 0;
   int   n_total = 0;
   int   cyc = 0;
   int   start_cyc_a = 0;
   bit   lat_arm_a = 1'b0;
   int   vcnt_a = 0;
   int   vcnt_b = 0;
   exp_t q_a[$];
   exp_t q_b[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_rx #(.I_CLK_FRQ(100_000_000), .BAUD(1_000_000), .PARITY(0), .FRAME(8), .STOP(1)) dut_a (
      .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx_a), .o_data(data_a), .o_valid(valid_a),
      .o_parity_err(perr_a), .o_frame_err(ferr_a), .o_busy(busy_a));

   uart_rx #(.I_CLK_FRQ(100_000_000), .BAUD(1_000_000), .PARITY(1), .FRAME(8), .STOP(1)) dut_b (
      .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx_b), .o_data(data_b), .o_valid(valid_b),
      .o_parity_err(perr_b), .o_frame_err(ferr_b), .o_busy(busy_b));

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic chk_rng(input string name, input int act, input int lo, input int hi);
      n_total++;
      if (act >= lo && act <= hi) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (valid_a) begin
         vcnt_a++;
         chk("a_valid_expected", int'(q_a.size() != 0), 1);
         if (q_a.size() != 0) begin
            e = q_a.pop_front();
            chk("a_data", int'(data_a), int'(e.d));
            chk("a_parity_err", int'(perr_a), int'(e.pe));
            chk("a_frame_err", int'(ferr_a), int'(e.fe));
         end
         if (lat_arm_a) begin
            lat_arm_a = 1'b0;
            chk_rng("a_valid_latency", cyc - start_cyc_a, 950, 954);
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (valid_b) begin
         vcnt_b++;
         chk("b_valid_expected", int'(q_b.size() != 0), 1);
         if (q_b.size() != 0) begin
            e = q_b.pop_front();
            chk("b_data", int'(data_b), int'(e.d));
            chk("b_parity_err", int'(perr_b), int'(e.pe));
            chk("b_frame_err", int'(ferr_b), int'(e.fe));
         end
      end
   end

   task automatic set_line(input int port, input logic v);
      if (port == 0) rx_a = v;
      else           rx_b = v;
   endtask

   task automatic hold_bit(input int port, input logic v, input int period);
      set_line(port, v);
      repeat (period) @(posedge clk);
      #1;
   endtask

   // par_bit < 0 means no parity bit on the line
   task automatic send_frame(input int port, input logic [7:0] data, input int par_bit,
                             input int period);
      if (port == 0) start_cyc_a = cyc;
      hold_bit(port, 1'b0, period);
      for (int i = 0; i < 8; i++) hold_bit(port, data[i], period);
      if (par_bit >= 0) hold_bit(port, par_bit[0], period);
      hold_bit(port, 1'b1, period);
   endtask

   task automatic wait_drain(input int port, input int budget);
      int n;
      n = 0;
      while (((port == 0) ? q_a.size() : q_b.size()) != 0 && n < budget) begin
         @(posedge clk);
         n++;
      end
      #1;
      chk((port == 0) ? "a_drain" : "b_drain", (port == 0) ? q_a.size() : q_b.size(), 0);
   endtask

   initial begin
      int busy_n;
      repeat (4) @(posedge clk);
      #1;
      chk("rst_data", int'(data_a), 0);
      chk("rst_valid", int'(valid_a), 0);
      chk("rst_perr", int'(perr_b), 0);
      chk("rst_ferr", int'(ferr_a), 0);
      chk("rst_busy", int'(busy_a), 0);
      rst_n = 1'b1;
      repeat (10) @(posedge clk);
      #1;

      // 8N1 byte with latency measurement
      q_a.push_back('{d: 8'hA5, pe: 1'b0, fe: 1'b0});
      lat_arm_a = 1'b1;
      send_frame(0, 8'hA5, -1, 100);
      wait_drain(0, 200);
      repeat (50) @(posedge clk);
      #1;

      // start glitch: 30 cycles low, receiver should give up at mid-start
      busy_n = 0;
      rx_a = 1'b0;
      for (int i = 0; i < 120; i++) begin
         if (i == 30) rx_a = 1'b1;
         @(posedge clk);
         #1;
         if (busy_a) busy_n++;
      end
      chk_rng("glitch_busy_cycles", busy_n, 45, 55);
      chk("glitch_data_held", int'(data_a), 'hA5);
      chk("glitch_ferr_held", int'(ferr_a), 0);

      // parity instance: wrong parity then correct parity
      q_b.push_back('{d: 8'h03, pe: 1'b1, fe: 1'b0});
      send_frame(1, 8'h03, 1, 100);
      wait_drain(1, 200);
      q_b.push_back('{d: 8'h07, pe: 1'b0, fe: 1'b0});
      send_frame(1, 8'h07, 1, 100);
      wait_drain(1, 200);

      // break: line low for three frame times gives exactly one flagged frame
      q_a.push_back('{d: 8'h00, pe: 1'b0, fe: 1'b1});
      rx_a = 1'b0;
      repeat (3000) @(posedge clk);
      #1;
      wait_drain(0, 10);
      rx_a = 1'b1;
      repeat (300) @(posedge clk);
      #1;
      chk("break_ferr_held", int'(ferr_a), 1);
      q_a.push_back('{d: 8'h3C, pe: 1'b0, fe: 1'b0});
      send_frame(0, 8'h3C, -1, 100);
      wait_drain(0, 200);
      repeat (50) @(posedge clk);
      #1;

      // back-to-back frames at a 3% slow transmitter
      q_a.push_back('{d: 8'h12, pe: 1'b0, fe: 1'b0});
      q_a.push_back('{d: 8'h34, pe: 1'b0, fe: 1'b0});
      send_frame(0, 8'h12, -1, 103);
      send_frame(0, 8'h34, -1, 103);
      wait_drain(0, 200);

      // reset pulse mid-frame; line is high from bit 4 on so no false start after release
      fork
         send_frame(0, 8'hF0, -1, 103);
         begin
            repeat (250) @(posedge clk);
            #2;
            rst_n = 1'b0;
            #1;
            chk("midrst_data", int'(data_a), 0);
            chk("midrst_busy", int'(busy_a), 0);
            chk("midrst_data_b", int'(data_b), 0);
            repeat (5) begin
               rx_b = 1'b0;
               repeat (3) @(posedge clk);
               rx_b = 1'b1;
               repeat (3) @(posedge clk);
            end
            repeat (320) @(posedge clk);
            #2;
            rst_n = 1'b1;
         end
      join
      repeat (300) @(posedge clk);
      #1;
      chk("after_rst_busy", int'(busy_a), 0);

      q_a.push_back('{d: 8'h5A, pe: 1'b0, fe: 1'b0});
      send_frame(0, 8'h5A, -1, 100);
      wait_drain(0, 200);
      repeat (100) @(posedge clk);
      #1;

      chk("a_valid_count", vcnt_a, 6);
      chk("b_valid_count", vcnt_b, 2);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit, got %0d/%0d", n_pass, n_total);
      $fatal(1, "watchdog");
   end

endmodule
